rv_ctrl_fsm: RTL and testbench

- Multicycle RISC-V RV32I control unit: the next generation of the combinational main decoder.
- Latches one instruction, decodes it, and sequences execute and memory phases against a handshaked data memory.
- Adds illegal-instruction and memory-timeout traps, plus a flush input.
- Sits between the fetch unit and the datapath; `enpc` now pulses once per retired instruction instead of being tied high.

---
 rtl/rv_ctrl_pkg.sv | 43 ++++
 rtl/rv_dec_comb.sv | 72 +++++++
 rtl/rv_ctrl_fsm.sv | 145 ++++++++++++++
 tb/tb_rv_ctrl_fsm.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the multicycle RV32I control unit: opcode classes,
// operand-select encodings, trap cause codes and FSM state codes.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_L     = 7'h03;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_B     = 7'h63;
  localparam logic [6:0] OP_J     = 7'h6F;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;

  localparam logic [1:0] SRCA_RS1   = 2'd0;
  localparam logic [1:0] SRCA_PC    = 2'd1;
  localparam logic [1:0] SRCA_ZERO  = 2'd2;
  localparam logic [1:0] SRCA_STORE = 2'd3;

  localparam logic [2:0] SRCB_RS2   = 3'd0;
  localparam logic [2:0] SRCB_IMM_I = 3'd1;
  localparam logic [2:0] SRCB_IMM_U = 3'd2;
  localparam logic [2:0] SRCB_IMM_S = 3'd3;
  localparam logic [2:0] SRCB_FOUR  = 3'd4;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MEM  = 2'd2;
  localparam logic [1:0] ST_TRAP = 2'd3;

  // addi x0, x0, 0 -- the instruction register holds this out of reset
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Memory interface code: direction (10 = load, 01 = store) above funct3
  function automatic logic [4:0] mem_code(input logic [1:0] dir, input logic [2:0] f3);
    return {dir, f3};
  endfunction

endpackage

// File: rtl/rv_dec_comb.sv
// Purely combinational decode of the instruction register into static
// datapath controls, opcode class flags and the illegal-instruction flag.
module rv_dec_comb
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic [1:0]  srca,
  output logic [2:0]  srcb,
  output logic [4:0]  memi,
  output logic [4:0]  aop,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_jal,
  output logic        is_jalr,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_r, is_i, is_lui, is_auipc, known;
  logic       unused_ir_bits;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];

  // Register and immediate fields are consumed by the datapath, not here
  assign unused_ir_bits = ^{ir[24:15], ir[11:7]};

  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_L);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_store  = (opcode == OP_S);
  assign is_branch = (opcode == OP_B);
  assign is_jal    = (opcode == OP_J);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);

  assign known = is_r | is_i | is_load | is_jalr | is_store | is_branch |
                 is_jal | is_lui | is_auipc;

  // Unsupported load widths, store widths beyond word, and R-type funct7
  // values other than the base/alternate encodings are all rejected
  assign illegal = !known ||
                   (is_load  && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ||
                   (is_store && (f3 > 3'd2)) ||
                   (is_r     && (f7 != 7'h00) && (f7 != 7'h20));

  // Operand selects, memory code and ALU operation from the opcode class
  always_comb begin
    srca = SRCA_RS1;
    srcb = SRCB_RS2;
    memi = '0;
    aop  = '0;
    if (is_jalr || is_jal || is_auipc) srca = SRCA_PC;
    else if (is_lui)                   srca = SRCA_ZERO;
    else if (is_store)                 srca = SRCA_STORE;
    if (is_i || is_load)               srcb = SRCB_IMM_I;
    else if (is_lui || is_auipc)       srcb = SRCB_IMM_U;
    else if (is_store)                 srcb = SRCB_IMM_S;
    else if (is_jal || is_jalr)        srcb = SRCB_FOUR;
    if (is_load)       memi = mem_code(2'b10, f3);
    else if (is_store) memi = mem_code(2'b01, f3);
    if (is_r)                  aop = {f7[6:5], f3};
    else if (is_i || is_load)  aop = {2'b00, f3};
    else if (is_branch)        aop = {2'b11, f3};
  end

endmodule

// File: rtl/rv_ctrl_fsm.sv
// Multicycle RV32I control unit: latches one instruction from fetch, runs an
// execute phase, optionally a handshaked memory phase, and retires it with a
// single enpc pulse. Illegal instructions and memory timeouts park in TRAP
// until acknowledged; flush aborts whatever is in flight.
module rv_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 16,
  parameter int ILLEGAL_TRAP = 1,
  parameter int CNT_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        flush,
  input  logic        mem_ready,
  input  logic        trap_ack,
  output logic        mem_req,
  output logic        enpc,
  output logic        jal,
  output logic        jalr,
  output logic        b,
  output logic        ws,
  output logic [4:0]  memi,
  output logic        mwe,
  output logic        rfwe,
  output logic [4:0]  aop,
  output logic [1:0]  srcA,
  output logic [2:0]  srcB,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic        busy
);

  // Last counter value before the memory phase gives up
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]       state, state_next;
  logic [31:0]      ir, ir_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       cause_next;
  logic             is_load, is_store, is_branch, illegal;

  rv_dec_comb u_dec (
    .ir        (ir),
    .srca      (srcA),
    .srcb      (srcB),
    .memi      (memi),
    .aop       (aop),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_jal    (jal),
    .is_jalr   (jalr),
    .illegal   (illegal)
  );

  assign ws          = is_load;
  assign b           = is_branch;
  assign busy        = (state != ST_IDLE);
  assign trap        = (state == ST_TRAP);
  assign instr_ready = (state == ST_IDLE) && !flush;

  // Next-state logic and the gated enables; flush overrides every state
  always_comb begin
    state_next = state;
    ir_next    = ir;
    cnt_next   = cnt;
    cause_next = trap_cause;
    enpc       = 1'b0;
    rfwe       = 1'b0;
    mwe        = 1'b0;
    mem_req    = 1'b0;
    if (flush) begin
      state_next = ST_IDLE;
      cause_next = CAUSE_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            ir_next    = instr;
            state_next = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (illegal) begin
            if (ILLEGAL_TRAP != 0) begin
              state_next = ST_TRAP;
              cause_next = CAUSE_ILLEGAL;
            end else begin
              enpc       = 1'b1;
              state_next = ST_IDLE;
            end
          end else if (is_load || is_store) begin
            cnt_next   = '0;
            state_next = ST_MEM;
          end else begin
            enpc       = 1'b1;
            rfwe       = !is_branch;
            state_next = ST_IDLE;
          end
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mwe     = is_store;
          if (mem_ready) begin
            enpc       = 1'b1;
            rfwe       = is_load;
            state_next = ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            state_next = ST_TRAP;
            cause_next = CAUSE_TIMEOUT;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ST_TRAP: begin
          if (trap_ack) begin
            cause_next = CAUSE_NONE;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State, instruction register, timeout counter and trap cause registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ir         <= NOP_INSTR;
      cnt        <= '0;
      trap_cause <= CAUSE_NONE;
    end else begin
      state      <= state_next;
      ir         <= ir_next;
      cnt        <= cnt_next;
      trap_cause <= cause_next;
    end
  end

endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Randomised scoreboard bench for rv_ctrl_fsm. Each issued instruction pushes
// its expected retire/trap record; a monitor pops a record whenever the DUT
// pulses enpc or enters TRAP. A second instance covers ILLEGAL_TRAP = 0.
module tb_rv_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, flush, mem_ready, trap_ack;
  logic [31:0] instr;
  logic        instr_ready, mem_req, enpc, jal, jalr, b, ws, mwe, rfwe, trap, busy;
  logic [4:0]  memi, aop;
  logic [1:0]  srcA, trap_cause;
  logic [2:0]  srcB;

  logic        n_instr_valid, n_flush, n_mem_ready, n_trap_ack;
  logic [31:0] n_instr;
  logic        n_instr_ready, n_mem_req, n_enpc, n_jal, n_jalr, n_b, n_ws, n_mwe, n_rfwe, n_trap, n_busy;
  logic [4:0]  n_memi, n_aop;
  logic [1:0]  n_srcA, n_trap_cause;
  logic [2:0]  n_srcB;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit is_trap;
    int cause;
    bit rfwe, ws, mwe;
    int memi, aop, srca, srcb;
    bit jal, jalr, b;
    int mem_cycles;
    bit uses_mem;
  } exp_t;

  exp_t sb_q[$];
  int   mem_cnt   = 0;
  bit   trap_prev = 0;

  always #5 clk = ~clk;

  rv_ctrl_fsm #(.MEM_TIMEOUT(16), .ILLEGAL_TRAP(1)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .flush(flush), .mem_ready(mem_ready),
    .trap_ack(trap_ack), .mem_req(mem_req), .enpc(enpc), .jal(jal),
    .jalr(jalr), .b(b), .ws(ws), .memi(memi), .mwe(mwe), .rfwe(rfwe),
    .aop(aop), .srcA(srcA), .srcB(srcB), .trap(trap),
    .trap_cause(trap_cause), .busy(busy)
  );

  rv_ctrl_fsm #(.MEM_TIMEOUT(2), .ILLEGAL_TRAP(0)) dut_nt (
    .clk(clk), .rst(rst), .instr_valid(n_instr_valid), .instr(n_instr),
    .instr_ready(n_instr_ready), .flush(n_flush), .mem_ready(n_mem_ready),
    .trap_ack(n_trap_ack), .mem_req(n_mem_req), .enpc(n_enpc), .jal(n_jal),
    .jalr(n_jalr), .b(n_b), .ws(n_ws), .memi(n_memi), .mwe(n_mwe), .rfwe(n_rfwe),
    .aop(n_aop), .srcA(n_srcA), .srcB(n_srcB), .trap(n_trap),
    .trap_cause(n_trap_cause), .busy(n_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: what the unit should report when this instruction finishes
  function automatic exp_t model(input logic [31:0] w, input int delay, input int timeout);
    exp_t  e;
    string cls;
    int    f3, f7;
    bit    bad;
    e  = '{default: 0};
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    case (w[6:0])
      7'h33: cls = "R";
      7'h13: cls = "I";
      7'h03: cls = "L";
      7'h67: cls = "JALR";
      7'h23: cls = "S";
      7'h63: cls = "B";
      7'h6F: cls = "J";
      7'h37: cls = "LUI";
      7'h17: cls = "AUIPC";
      default: cls = "?";
    endcase
    if (cls == "JALR" || cls == "J" || cls == "AUIPC") e.srca = 1;
    if (cls == "LUI") e.srca = 2;
    if (cls == "S")   e.srca = 3;
    if (cls == "I" || cls == "L") e.srcb = 1;
    if (cls == "LUI" || cls == "AUIPC") e.srcb = 2;
    if (cls == "S") e.srcb = 3;
    if (cls == "J" || cls == "JALR") e.srcb = 4;
    if (cls == "L") e.memi = 16 + f3;
    if (cls == "S") e.memi = 8 + f3;
    if (cls == "R") e.aop = (f7 / 32) * 8 + f3;
    if (cls == "I" || cls == "L") e.aop = f3;
    if (cls == "B") e.aop = 24 + f3;
    e.ws   = (cls == "L");
    e.jal  = (cls == "J");
    e.jalr = (cls == "JALR");
    e.b    = (cls == "B");
    bad = (cls == "?") || (cls == "L" && (f3 == 3 || f3 >= 6)) ||
          (cls == "S" && f3 > 2) || (cls == "R" && f7 != 0 && f7 != 32);
    if (bad) begin
      e.is_trap = 1;
      e.cause   = 1;
    end else if (cls == "L" || cls == "S") begin
      e.uses_mem = 1;
      if (delay < 1 || delay > timeout) begin
        e.is_trap    = 1;
        e.cause      = 2;
        e.mem_cycles = timeout;
      end else begin
        e.rfwe       = (cls == "L");
        e.mwe        = (cls == "S");
        e.mem_cycles = delay;
      end
    end else begin
      e.rfwe = (cls != "B");
    end
    return e;
  endfunction

  function automatic logic [23:0] packExp(input exp_t e);
    return {e.is_trap, 2'(e.cause), e.rfwe, e.ws, e.mwe, 5'(e.memi), 5'(e.aop),
            2'(e.srca), 3'(e.srcb), e.jal, e.jalr, e.b};
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 10);
    case (k)
      0: begin
        w[6:0] = 7'h33;
        if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      1: w[6:0] = 7'h13;
      2, 9: w[6:0] = 7'h03;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h23;
      5: w[6:0] = 7'h63;
      6: w[6:0] = 7'h6F;
      7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;
      default: ;
    endcase
    return w;
  endfunction

  // Monitor: pops and compares one record per retire pulse or trap entry
  always @(negedge clk) begin
    if (rst) begin
      mem_cnt   = 0;
      trap_prev = 0;
    end else begin
      exp_t e;
      if (mem_req) mem_cnt++;
      checkOutput("rfwe_gate", 32'(rfwe & ~enpc), 0);
      checkOutput("mwe_gate", 32'(mwe & ~mem_req), 0);
      if (enpc || (trap && !trap_prev)) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_event", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          checkOutput("event_fields",
                      {8'h0, trap, trap_cause, rfwe, ws, mwe, memi, aop, srcA, srcB, jal, jalr, b},
                      {8'h0, packExp(e)});
          checkOutput("mem_cycles", mem_cnt, e.mem_cycles);
        end
        mem_cnt = 0;
      end
      if (!busy) mem_cnt = 0;
      trap_prev = trap;
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctrl"},
                {23'h0, instr_ready, busy, trap, trap_cause, enpc, rfwe, mwe, mem_req},
                {23'h0, 9'b1_0_0_00_0000});
    checkOutput({tag, "_nop_decode"},
                {12'h0, srcA, srcB, aop, memi, jal, jalr, b, ws},
                {12'h0, 2'd0, 3'd1, 5'd0, 5'd0, 4'b0000});
  endtask

  // Issue one instruction, drive the memory handshake, clear any trap
  task automatic applyStimulus(input logic [31:0] w, input int delay, input bit flush_trap);
    exp_t e;
    bit   done;
    e = model(w, delay, 16);
    @(posedge clk); #1;
    instr = w; instr_valid = 1'b1; mem_ready = 1'($urandom_range(0, 1));
    sb_q.push_back(e);
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = $urandom; mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    mem_ready = 1'b0;
    if (e.uses_mem) begin
      if (delay >= 1 && delay <= 16) begin
        repeat (delay - 1) begin @(posedge clk); #1; end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
      end else begin
        repeat (16) begin @(posedge clk); #1; end
      end
    end
    done = 0;
    for (int g = 0; g < 40 && !done; g++) begin
      @(negedge clk);
      if (!busy) done = 1;
      else if (trap) begin
        checkOutput("trap_cause_held", trap_cause, e.cause);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk); #1;
        if (flush_trap) flush = 1'b1;
        else trap_ack = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; trap_ack = 1'b0;
      end
    end
    checkOutput("return_to_idle", busy, 0);
    if (busy) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb_q.delete();
    end
  endtask

  task automatic flushInMem();
    @(posedge clk); #1; instr = 32'h0050A423; instr_valid = 1'b1;
    @(posedge clk); #1; instr_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("mem1_mwe", {mem_req, mwe}, 2'b11);
    @(posedge clk); #1; flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_mem_outputs", {instr_ready, enpc, rfwe, mwe, mem_req}, 5'b00000);
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_mem_idle", {instr_ready, busy, trap, trap_cause, enpc}, 6'b100000);
  endtask

  task automatic flushInIdle();
    @(posedge clk); #1; instr = 32'h002081B3; instr_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_idle_ready_gate", instr_ready, 0);
    @(posedge clk); #1; flush = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_idle_no_transfer", busy, 0);
  endtask

  task automatic resetInExec();
    @(posedge clk); #1; instr = 32'h002081B3; instr_valid = 1'b1;
    @(posedge clk); #1; instr_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("reset_mid_exec");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("after_reset_release");
  endtask

  task automatic nonTrappingVariant();
    @(posedge clk); #1; n_instr = 32'hFFFFFFFF; n_instr_valid = 1'b1;
    @(posedge clk); #1; n_instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("nt_illegal_retire", {n_enpc, n_rfwe, n_mwe, n_trap}, 4'b1000);
    @(negedge clk);
    checkOutput("nt_illegal_idle", {n_busy, n_enpc, n_trap_cause}, 4'b0000);
    @(posedge clk); #1; n_instr = 32'h0040A283; n_instr_valid = 1'b1;
    @(posedge clk); #1; n_instr_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("nt_mem1_req", n_mem_req, 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("nt_mem2_req", n_mem_req, 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("nt_timeout_trap", {n_trap, n_trap_cause, n_mem_req, n_enpc}, 5'b11000);
    @(posedge clk); #1; n_trap_ack = 1'b1;
    @(posedge clk); #1; n_trap_ack = 1'b0;
    @(negedge clk);
    checkOutput("nt_trap_cleared", {n_busy, n_trap_cause, n_instr_ready}, 4'b0001);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   d, r;
    rst = 1'b1;
    instr_valid = 1'b0; instr = '0; flush = 1'b0; mem_ready = 1'b0; trap_ack = 1'b0;
    n_instr_valid = 1'b0; n_instr = '0; n_flush = 1'b0; n_mem_ready = 1'b0; n_trap_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("reset");

    $display("[TB] directed add/lw/sw/timeout/illegal");
    applyStimulus(32'h002081B3, 0, 0);
    checkOutput("add_ready_cycle3", instr_ready, 1);
    applyStimulus(32'h0040A283, 3, 0);
    applyStimulus(32'h0050A423, 1, 0);
    applyStimulus(32'h0040A283, 0, 0);
    checkOutput("timeout_cause_cleared", trap_cause, 0);
    applyStimulus(32'hFFFFFFFF, 0, 0);
    applyStimulus(32'hFFFFFFFF, 0, 1);
    checkOutput("flush_trap_cause_cleared", trap_cause, 0);
    applyStimulus(32'h0040A283, 16, 0);

    $display("[TB] flush and reset scenarios");
    flushInMem();
    flushInIdle();
    resetInExec();

    $display("[TB] randomised instructions");
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      d = (r == 9) ? 16 : r;
      applyStimulus(randInstr(), d, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] ILLEGAL_TRAP = 0 instance");
    nonTrappingVariant();

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
